// File: rtl/lane_grid_scroller.sv
// ---------------------------------------------------------------------------
// lane_grid_scroller
//
// Playfield overlay that draws NUM_LANES vertical dividers. Each divider is a
// solid left rail, a dashed centre column and a solid right rail. The dashes
// scroll vertically once per frame under run / pause / single-step control.
// Sits between the VGA controller and the colour mapper.
//
// Ports
//   Clk        in   pixel-domain clock
//   Reset      in   synchronous, active-high reset
//   frame_clk  in   vsync-rate strobe; rising edge marks a frame boundary
//   DrawX      in   current pixel X (10 bits)
//   DrawY      in   current pixel Y (10 bits), +1 per line, 0 at frame start
//   scroll_en  in   1 = run, 0 = pause
//   step       in   one-cycle pulse requesting a single advance while paused
//   dir        in   0 = pattern moves down, 1 = pattern moves up
//   speed      in   rows advanced per frame (0..15)
//   grid_on    out  rail_on | dash_on
//   rail_on    out  pixel is on a solid rail
//   dash_on    out  pixel is on a lit dash segment
//   lane_idx   out  index of the divider hit, 0 when grid_on = 0
//   offset     out  current scroll offset, 0..DASH_PERIOD-1
//
// Pixel outputs appear two Clk cycles after DrawX/DrawY.
// ---------------------------------------------------------------------------
module lane_grid_scroller #(
    parameter int NUM_LANES   = 2,
    parameter int LANE0_X     = 170,
    parameter int LANE_PITCH  = 280,
    parameter int RAIL_W      = 5,
    parameter int DASH_W      = 10,
    parameter int DASH_PERIOD = 40,
    parameter int DASH_ON     = 20
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       scroll_en,
    input  logic       step,
    input  logic       dir,
    input  logic [3:0] speed,
    output logic       grid_on,
    output logic       rail_on,
    output logic       dash_on,
    output logic [2:0] lane_idx,
    output logic [7:0] offset
);

    localparam logic [7:0] L_P       = 8'(DASH_PERIOD);
    localparam logic [7:0] L_DASH_ON = 8'(DASH_ON);

    typedef enum logic [1:0] {
        ST_PAUSE     = 2'd0,
        ST_RUN       = 2'd1,
        ST_STEP_PEND = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Frame edge detect
    // -----------------------------------------------------------------------
    logic r_frame_q;
    logic w_fe;

    assign w_fe = frame_clk & ~r_frame_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_frame_q <= 1'b0;
        end else begin
            r_frame_q <= frame_clk;
        end
    end

    // -----------------------------------------------------------------------
    // Scroll control state machine
    // -----------------------------------------------------------------------
    state_t r_state;
    state_t w_state_next;
    logic   w_advance;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_PAUSE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        case (r_state)
            ST_PAUSE: begin
                // Run wins over a simultaneous step; the step is dropped.
                if (scroll_en) begin
                    w_state_next = ST_RUN;
                end else if (step) begin
                    w_state_next = ST_STEP_PEND;
                end
            end
            ST_RUN: begin
                // A frame edge on the same cycle as scroll_en falling still
                // counts, since that frame was started while running.
                w_advance = w_fe;
                if (!scroll_en) begin
                    w_state_next = ST_PAUSE;
                end
            end
            ST_STEP_PEND: begin
                // Extra step pulses are simply ignored while waiting.
                if (w_fe) begin
                    w_advance    = 1'b1;
                    w_state_next = scroll_en ? ST_RUN : ST_PAUSE;
                end
            end
            default: begin
                w_state_next = ST_PAUSE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Offset advance: modular add/subtract with one conditional correction
    // by P. All intermediates stay within 8 bits because offset < P and the
    // clamped step is < P.
    // -----------------------------------------------------------------------
    logic [7:0] r_offset;
    logic [7:0] w_spd;
    logic [7:0] w_room;
    logic [7:0] w_off_up;
    logic [7:0] w_off_dn;
    logic [7:0] w_off_adv;

    assign w_spd    = ({4'd0, speed} >= L_P) ? (L_P - 8'd1) : {4'd0, speed};
    // Distance to the wrap point; offset + spd >= P exactly when spd >= room.
    assign w_room   = L_P - r_offset;
    assign w_off_up = (w_spd >= w_room) ? (w_spd - w_room) : (r_offset + w_spd);
    assign w_off_dn = (r_offset >= w_spd) ? (r_offset - w_spd)
                                          : (r_offset + (L_P - w_spd));
    assign w_off_adv = dir ? w_off_up : w_off_dn;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_offset <= 8'd0;
        end else if (w_advance) begin
            r_offset <= w_off_adv;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: register pixel coordinates and track the row phase
    // ph = (DrawY + offset) mod P, built incrementally per line so that no
    // divider is needed. The offset is sampled only at DrawY == 0, so a
    // mid-frame advance never tears the current frame.
    // -----------------------------------------------------------------------
    logic [9:0] r_x1;
    logic [9:0] r_y1;
    logic [7:0] r_ph;
    logic       w_y_changed;
    logic [7:0] w_ph_next;

    assign w_y_changed = (DrawY != r_y1);
    assign w_ph_next   = (DrawY == 10'd0)      ? r_offset :
                         (r_ph == L_P - 8'd1)  ? 8'd0     :
                                                 (r_ph + 8'd1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_x1 <= 10'd0;
            r_y1 <= 10'd0;
            r_ph <= 8'd0;
        end else begin
            r_x1 <= DrawX;
            r_y1 <= DrawY;
            if (w_y_changed) begin
                r_ph <= w_ph_next;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2 geometry decode (one comparator set per divider)
    // -----------------------------------------------------------------------
    logic [31:0]          w_x32;
    logic [NUM_LANES-1:0] w_rail_hit;
    logic [NUM_LANES-1:0] w_dcol_hit;
    logic [NUM_LANES-1:0] w_dash_hit;
    logic                 w_lit;

    assign w_x32 = {22'd0, r_x1};
    assign w_lit = (r_ph < L_DASH_ON);

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            localparam logic [31:0] L_RAIL0 = 32'(LANE0_X + gi * LANE_PITCH);
            localparam logic [31:0] L_DASH0 = L_RAIL0 + 32'(RAIL_W);
            localparam logic [31:0] L_RAIL1 = L_DASH0 + 32'(DASH_W);
            localparam logic [31:0] L_END   = L_RAIL1 + 32'(RAIL_W);

            assign w_rail_hit[gi] = ((w_x32 >= L_RAIL0) && (w_x32 < L_DASH0)) ||
                                    ((w_x32 >= L_RAIL1) && (w_x32 < L_END));
            assign w_dcol_hit[gi] = (w_x32 >= L_DASH0) && (w_x32 < L_RAIL1);
            assign w_dash_hit[gi] = w_dcol_hit[gi] & w_lit;
        end
    endgenerate

    // Dividers never overlap, so at most one bit is set and a priority-free
    // scan yields the matching index (or 0 for no match).
    logic [2:0] w_lane;

    always_comb begin
        w_lane = 3'd0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (w_rail_hit[k] || w_dash_hit[k]) begin
                w_lane = 3'(k);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2 output registers
    // -----------------------------------------------------------------------
    logic       r_rail;
    logic       r_dash;
    logic       r_grid;
    logic [2:0] r_lane;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rail <= 1'b0;
            r_dash <= 1'b0;
            r_grid <= 1'b0;
            r_lane <= 3'd0;
        end else begin
            r_rail <= |w_rail_hit;
            r_dash <= |w_dash_hit;
            r_grid <= (|w_rail_hit) | (|w_dash_hit);
            r_lane <= w_lane;
        end
    end

    assign rail_on  = r_rail;
    assign dash_on  = r_dash;
    assign grid_on  = r_grid;
    assign lane_idx = r_lane;
    assign offset   = r_offset;

endmodule

// File: tb/tb_lane_grid_scroller.sv
module tb_lane_grid_scroller;

    localparam int NUM_LANES  = 2;
    localparam int LANE0_X    = 170;
    localparam int LANE_PITCH = 280;
    localparam int RAIL_W     = 5;
    localparam int DASH_W     = 10;
    localparam int P          = 40;
    localparam int DASH_ON    = 20;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       scroll_en;
    logic       step;
    logic       dir;
    logic [3:0] speed;
    logic       grid_on;
    logic       rail_on;
    logic       dash_on;
    logic [2:0] lane_idx;
    logic [7:0] offset;

    always #5 Clk = ~Clk;

    lane_grid_scroller #(
        .NUM_LANES  (NUM_LANES),
        .LANE0_X    (LANE0_X),
        .LANE_PITCH (LANE_PITCH),
        .RAIL_W     (RAIL_W),
        .DASH_W     (DASH_W),
        .DASH_PERIOD(P),
        .DASH_ON    (DASH_ON)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .frame_clk(frame_clk),
        .DrawX    (DrawX),
        .DrawY    (DrawY),
        .scroll_en(scroll_en),
        .step     (step),
        .dir      (dir),
        .speed    (speed),
        .grid_on  (grid_on),
        .rail_on  (rail_on),
        .dash_on  (dash_on),
        .lane_idx (lane_idx),
        .offset   (offset)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int m_off;            // scroll offset
    bit m_fq;             // last frame_clk level
    bit m_run, m_pend;    // running / single step pending
    int y_prev;           // previous DrawY seen by the design
    int f_off;            // offset captured at the start of the current frame
    bit f_ok;             // frame phase known (frame started since reset)
    int s1_x, s1_ph;
    bit s1_ok;
    bit e_rail, e_dash, e_dc;
    int e_lane;
    bit chk_en = 1'b0;

    function automatic void pix(input int x, input int ph, input bit ok,
                                output bit r, output bit d, output bit dc, output int ln);
        r = 0; d = 0; dc = 0; ln = 0;
        for (int k = 0; k < NUM_LANES; k++) begin
            int o;
            o = x - (LANE0_X + k * LANE_PITCH);
            if ((o >= 0 && o < RAIL_W) ||
                (o >= RAIL_W + DASH_W && o < 2 * RAIL_W + DASH_W)) begin
                r = 1; ln = k;
            end else if (o >= RAIL_W && o < RAIL_W + DASH_W) begin
                if (!ok) dc = 1;
                else if (ph < DASH_ON) begin d = 1; ln = k; end
            end
        end
    endfunction

    function automatic int advance(input int off, input bit up, input int spd);
        int s;
        s = (spd >= P) ? P - 1 : spd;
        return up ? (off + s) % P : (off - s + P) % P;
    endfunction

    always @(posedge Clk) begin
        bit fe;
        if (Reset) begin
            e_rail = 0; e_dash = 0; e_dc = 0; e_lane = 0;
            s1_x = 0; s1_ph = 0; s1_ok = 1;
            m_off = 0; m_fq = 0; m_run = 0; m_pend = 0;
            y_prev = 0; f_off = 0; f_ok = 1;
        end else begin
            pix(s1_x, s1_ph, s1_ok, e_rail, e_dash, e_dc, e_lane);
            if (int'(DrawY) != y_prev) begin
                if (DrawY == 0) begin
                    f_off = m_off; f_ok = 1;
                end else if (int'(DrawY) != y_prev + 1) begin
                    f_ok = 0;
                end
            end
            y_prev = int'(DrawY);
            s1_x  = int'(DrawX);
            s1_ok = f_ok;
            s1_ph = (int'(DrawY) + f_off) % P;

            fe = frame_clk && !m_fq;
            m_fq = frame_clk;
            if (m_run) begin
                if (fe) m_off = advance(m_off, dir, int'(speed));
                if (!scroll_en) m_run = 0;
            end else if (m_pend) begin
                if (fe) begin
                    m_off = advance(m_off, dir, int'(speed));
                    m_pend = 0;
                    m_run = scroll_en;
                end
            end else begin
                if (scroll_en) m_run = 1;
                else if (step) m_pend = 1;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge Clk) begin
        if (chk_en) begin
            check("offset", {24'd0, offset}, m_off);
            check("rail_on", {31'd0, rail_on}, {31'd0, e_rail});
            if (!e_dc) begin
                check("dash_on", {31'd0, dash_on}, {31'd0, e_dash});
                check("grid_on", {31'd0, grid_on}, {31'd0, e_rail | e_dash});
                check("lane_idx", {29'd0, lane_idx}, e_lane);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    int cur_y = 0;

    task automatic tick();
        @(posedge Clk); #1;
    endtask

    task automatic set_y(input int y, input int x);
        tick();
        DrawY = 10'(y); DrawX = 10'(x); cur_y = y;
    endtask

    task automatic walk_to(input int yt, input int x);
        while (cur_y < yt) set_y(cur_y + 1, x);
    endtask

    task automatic probe(input string nm, input int x, input int y,
                         input bit er, input bit ed, input int el);
        set_y(y, x);
        @(posedge Clk); @(posedge Clk); @(negedge Clk);
        check({nm, ".rail"}, {31'd0, rail_on}, {31'd0, er});
        check({nm, ".dash"}, {31'd0, dash_on}, {31'd0, ed});
        check({nm, ".grid"}, {31'd0, grid_on}, {31'd0, er | ed});
        check({nm, ".lane"}, {29'd0, lane_idx}, el);
    endtask

    task automatic pulse_fe();
        tick(); frame_clk = 1'b1;
        tick(); frame_clk = 1'b0;
    endtask

    task automatic pulse_step();
        tick(); step = 1'b1;
        tick(); step = 1'b0;
    endtask

    task automatic check_off(input string nm, input int exp);
        @(negedge Clk);
        check(nm, {24'd0, offset}, exp);
    endtask

    function automatic int pick_x();
        if ($urandom_range(0, 1) == 0)
            return LANE0_X + int'($urandom_range(0, NUM_LANES - 1)) * LANE_PITCH
                   + int'($urandom_range(0, 2 * RAIL_W + DASH_W + 1)) - 1;
        return int'($urandom_range(0, 639));
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int lines;
        Reset = 1'b1; frame_clk = 1'b0; DrawX = '0; DrawY = '0;
        scroll_en = 1'b0; step = 1'b0; dir = 1'b0; speed = 4'd0;
        tick(); tick();
        chk_en = 1'b1;
        @(negedge Clk);
        check("rst.offset", {24'd0, offset}, 0);
        check("rst.grid", {31'd0, grid_on}, 0);
        tick(); Reset = 1'b0;

        // Static pattern at offset 0
        probe("s172", 172, 0, 1, 0, 0);
        walk_to(9, 177);
        probe("s177y10", 177, 10, 0, 1, 0);
        walk_to(24, 177);
        probe("s177y25", 177, 25, 0, 0, 0);
        probe("s300", 300, 25, 0, 0, 0);
        walk_to(44, 457);
        probe("l1dash", 457, 45, 0, 1, 1);
        probe("l1rail", 467, 45, 1, 0, 1);

        // Scroll down by 5 -> 35
        tick(); scroll_en = 1'b1; dir = 1'b0; speed = 4'd5;
        pulse_fe();
        tick(); scroll_en = 1'b0;
        check_off("down35", 35);
        set_y(0, 177);
        for (int y = 0; y < 5; y++) probe("dn_off", 177, y, 0, 0, 0);
        probe("dn_y5", 177, 5, 0, 1, 0);
        walk_to(23, 177);
        probe("dn_y24", 177, 24, 0, 1, 0);
        probe("dn_y25", 177, 25, 0, 0, 0);

        // Down to 30, then wrap upward with speed 15
        tick(); scroll_en = 1'b1;
        pulse_fe();                 check_off("down30", 30);
        tick(); dir = 1'b1; speed = 4'd15;
        pulse_fe();                 check_off("up5", 5);
        pulse_fe();                 check_off("up20", 20);
        pulse_fe();                 check_off("up35", 35);
        pulse_fe();                 check_off("up10", 10);

        // Pause and single step
        tick(); scroll_en = 1'b0;
        repeat (3) pulse_fe();
        check_off("pause_hold", 10);
        pulse_step();
        pulse_fe();                 check_off("step1", 25);
        pulse_fe();                 check_off("step_once", 25);
        pulse_step(); pulse_step();
        pulse_fe();                 check_off("step2x", 0);
        pulse_fe();                 check_off("step2x_hold", 0);

        // Reset mid-frame while running at offset 35
        tick(); scroll_en = 1'b1; dir = 1'b0; speed = 4'd5;
        pulse_fe();                 check_off("pre_rst35", 35);
        set_y(0, 172);
        walk_to(200, 172);
        tick(); Reset = 1'b1; scroll_en = 1'b0;
        tick(); Reset = 1'b0; frame_clk = 1'b1;
        @(negedge Clk);
        check("rst1.offset", {24'd0, offset}, 0);
        check("rst1.rail", {31'd0, rail_on}, 0);
        tick(); frame_clk = 1'b0;
        @(negedge Clk);
        check("rst2.rail", {31'd0, rail_on}, 0);
        check("rst2.offset", {24'd0, offset}, 0);
        @(negedge Clk);
        check("rst3.rail", {31'd0, rail_on}, 1);
        set_y(0, 177);
        probe("resume", 177, 0, 0, 1, 0);

        // Randomised frames
        for (int f = 0; f < 25; f++) begin
            lines = int'($urandom_range(10, 70));
            for (int y = 0; y <= lines; y++) begin
                for (int j = 0; j < 4; j++) begin
                    set_y(y, pick_x());
                    if ($urandom_range(0, 15) == 0) scroll_en = ~scroll_en;
                    step = ($urandom_range(0, 20) == 0);
                    if ($urandom_range(0, 30) == 0) begin
                        dir = 1'($urandom_range(0, 1));
                        speed = 4'($urandom_range(0, 15));
                    end
                    if ($urandom_range(0, 25) == 0) frame_clk = ~frame_clk;
                    Reset = ($urandom_range(0, 3000) == 0);
                end
            end
        end
        tick(); Reset = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/lane_grid_scroller.md
Name: lane_grid_scroller

Overview:
- Parametrised successor to the fixed two-divider playfield grid overlay.
- Draws NUM_LANES vertical dividers. Each divider is a solid left rail, a dashed centre column and a solid right rail.
- Dashes scroll vertically once per frame, with run/pause/single-step control.
- Sits between the VGA controller (DrawX/DrawY, frame_clk) and the colour mapper. The colour mapper consumes grid_on, rail_on, dash_on and lane_idx.

Parameters:
- NUM_LANES, 2, number of dividers (1..8).
- LANE0_X, 170, left edge of divider 0 (pixels).
- LANE_PITCH, 280, X distance between successive divider left edges.
- RAIL_W, 5, width of each solid rail.
- DASH_W, 10, width of the dashed centre column.
- DASH_PERIOD, 40, vertical dash period P (16..255).
- DASH_ON, 20, lit rows per period (1..P-1).

Ports:
- Clk  in  1  pixel-domain clock
- Reset  in  1  synchronous, active-high
- frame_clk  in  1  vsync-rate strobe; its rising edge marks a frame boundary
- DrawX  in  10  current pixel X
- DrawY  in  10  current pixel Y; must advance by +1 per line and return to 0 each frame
- scroll_en  in  1  1 = run, 0 = pause
- step  in  1  single-cycle pulse; requests one advance while paused
- dir  in  1  0 = pattern moves down, 1 = pattern moves up
- speed  in  4  rows advanced per frame (0..15)
- grid_on  out  1  rail_on | dash_on
- rail_on  out  1  pixel is on a solid rail
- dash_on  out  1  pixel is on a lit dash segment
- lane_idx  out  3  index of the divider hit; 0 when grid_on=0
- offset  out  8  current scroll offset, 0..P-1

Behaviour:
- Reset, applied synchronously on any cycle including mid-frame:
  - offset=0, row phase=0, edge-detect register=0, state=PAUSE.
  - All outputs 0 on the following cycle.
- Geometry of divider k, with base Xk = LANE0_X + k*LANE_PITCH:
  - Left rail: Xk <= X < Xk+RAIL_W.
  - Dash column: Xk+RAIL_W <= X < Xk+RAIL_W+DASH_W.
  - Right rail: the next RAIL_W pixels.
  - Dividers never overlap (LANE_PITCH >= 2*RAIL_W+DASH_W). At most one divider matches a pixel.
- Row phase register ph:
  - Tracks (DrawY + offset) mod P.
  - Updated on cycles where DrawY differs from its registered copy.
  - If the new DrawY==0, ph <= offset. Otherwise ph <= ph+1, wrapping from P-1 to 0.
  - No divider/modulo hardware is permitted.
- Dash lit condition: ph < DASH_ON.
- Pipeline: two stages.
  - Stage 1 registers DrawX and DrawY and updates ph.
  - Stage 2 registers all outputs from the stage-1 DrawX and ph.
  - Latency is 2 Clk cycles from DrawX/DrawY to the outputs.
- Frame edge (fe): frame_clk registered once; fe = frame_clk & ~frame_clk_q. fe is a one-cycle pulse.
- Advance operation: offset <= (offset + speed) mod P when dir=1, or (offset - speed) mod P when dir=0.
  - Use a single conditional add/subtract of P.
  - The result always stays in 0..P-1.
  - speed >= P is clamped to P-1.
- State machine, with transitions evaluated every cycle:
  - PAUSE: scroll_en=1 -> RUN. Else if step=1 -> STEP_PEND. Offset holds.
  - RUN: on fe, advance. If scroll_en=0 -> PAUSE, with no advance unless fe occurs on the same cycle.
  - STEP_PEND: on fe, advance exactly once, then go to RUN if scroll_en=1, otherwise PAUSE. Further step pulses while pending are ignored.
- Offset changes only on an fe cycle, so no mid-frame tearing once ph has reloaded at DrawY==0.
- Simultaneous scroll_en=1 and step in PAUSE: RUN takes priority and the step is dropped.
- lane_idx holds the matched k for both rails and the dash. It is 0 when nothing matches.

Test Plan:
- Static pattern, defaults, after reset, no scroll:
  - DrawX=172, any Y -> rail_on=1, grid_on=1.
  - DrawX=177, DrawY=10 -> dash_on=1.
  - DrawX=177, DrawY=25 -> grid_on=0.
  - DrawX=300 -> grid_on=0.
  - All results appear 2 cycles after the stimulus.
- Second lane: DrawX=457, DrawY=45 -> dash_on=1, lane_idx=1. DrawX=467 -> rail_on=1, lane_idx=1.
- Scroll down: scroll_en=1, dir=0, speed=5, one frame_clk rise -> offset=35.
  - Next frame, X=177: DrawY=0..4 -> dash_on=0; DrawY=5 -> dash_on=1; DrawY=24 -> dash_on=1; DrawY=25 -> dash_on=0.
- Wrap up: offset=30, dir=1, speed=15, fe -> offset=5. Then speed=15 held for 3 more frames -> offset 20, 35, 10.
- Pause/step: scroll_en=0 with 3 frames elapsing -> offset unchanged.
  - step pulse, then 1 fe -> offset advances once.
  - Second fe -> no change.
  - Two step pulses before an fe -> exactly one advance.
- Reset mid-frame during RUN, with offset=35 and DrawY=200 -> next cycle offset=0, state PAUSE. Outputs 0 for 2 cycles, then the static pattern resumes.
